logs_pwm_capture: RTL

PWM audio demodulator: the receive-side counterpart of the logistic-map sonifier's PWM mixer output. It synchronizes a 1-bit PWM line, counts high clocks over fixed frames of 2^(K+M) clocks, and queues each frame's count as a sample in a small FIFO with a valid/ready output. It sits on the bench/loopback path, turning the sonifier's `snd` back into amplitude samples for checking or re-synthesis.

---
 rtl/logs_pwm_capture.sv | 84 ++++++++
 1 files changed

// File: rtl/logs_pwm_capture.sv
// PWM audio demodulator: synchronizes a 1-bit PWM line, counts high clocks per
// 2^(K+M)-clock frame and queues each frame count in a small valid/ready FIFO.
module logs_pwm_capture #(
    parameter int unsigned K     = 2,
    parameter int unsigned M     = 3,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         pwm_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [K+M:0] out_data,
    output logic         overrun,
    input  logic         overrun_clr
);
    localparam int unsigned FW = K + M;
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic          s1, s2;
    logic [FW-1:0] fcnt;
    logic [FW:0]   acc;
    logic [FW:0]   mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   count;

    logic          frame_end, pop, full, push_ok, drop;
    logic [FW:0]   push_val;

    always_comb begin
        frame_end = en && (fcnt == '1);
        push_val  = acc + {{FW{1'b0}}, s2};
        pop       = out_valid && out_ready;
        full      = (count == FULL_CNT);
        // When full, a simultaneous pop frees the slot the push lands in.
        push_ok   = frame_end && (!full || pop);
        drop      = frame_end && full && !pop;
        out_valid = (count != '0);
        out_data  = out_valid ? mem[rptr] : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1      <= 1'b0;
            s2      <= 1'b0;
            fcnt    <= '0;
            acc     <= '0;
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            s1 <= pwm_in;
            s2 <= s1;

            if (!en) begin
                fcnt <= '0;
                acc  <= '0;
            end else begin
                fcnt <= fcnt + 1'b1;
                acc  <= frame_end ? '0 : push_val;
            end

            if (push_ok) wptr <= wptr + 1'b1;
            if (pop)     rptr <= rptr + 1'b1;

            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (drop)             overrun <= 1'b1;
            else if (overrun_clr) overrun <= 1'b0;
        end
    end

    // Sample storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr] <= push_val;
    end
endmodule
